i2c_req_arbiter: RTL
====================

// Module: i2c_req_arbiter
// PURPOSE
// Shares one i2c_mmaster byte-transaction engine between NREQ local requesters.
// Picks one requester round-robin, latches its descriptor, launches the master, steers read/write byte strobes
// back to that requester, and pulses done (or err) at completion.
// Sits between client blocks (sensor pollers, config loaders) and the single I2C master instance.
// PARAMETERS
// NREQ       4    number of requesters (2..8)
// START_TO   16   cycles to wait for m_busy_i to rise after launch before flagging err
// PORTS
// clock_i      in   1        system/I2C controller clock (same clock as the master)
// reset_i      in   1        asynchronous reset, active high
// req_i        in   NREQ     per-requester transaction request (level, held until done/err)
// rw_i         in   NREQ     per-requester read(1)/write(0)
// ur_i         in   NREQ     per-requester use-register-address flag
// devadr_i     in   7*NREQ   per-requester 7-bit device address, requester k at [7k+6:7k]
// regadr_i     in   8*NREQ   per-requester register address
// datnum_i     in   16*NREQ  per-requester byte count
// wdat_i       in   8*NREQ   per-requester current write byte
// gnt_o        out  NREQ     one-hot grant, high from latch until done/err cycle inclusive
// wnext_o      out  NREQ     1-cycle pulse: granted requester's write byte taken, present the next one
// rvalid_o     out  NREQ     1-cycle pulse: rdat_o holds a valid read byte for the granted requester
// rdat_o       out  8        read byte (shared bus, qualified by rvalid_o)
// done_o       out  NREQ     1-cycle pulse: transaction finished normally
// err_o        out  NREQ     1-cycle pulse: master never went busy (start timeout)
// m_enable_o   out  1        master enable
// m_rw_o, m_ur_o  out 1      master rw/ur, from latched descriptor
// m_devadr_o   out  7        master device address
// m_regadr_o   out  8        master register address
// m_datnum_o   out  16       master byte count
// m_dat_o      out  8        master write data = wdat_i of granted requester (combinational mux)
// m_dat_i      in   8        master read data
// m_busy_i     in   1        master busy
// m_dvalid_i   in   1        master byte strobe
// BEHAVIOUR
// - Reset (async): state IDLE, all outputs 0, round-robin pointer 0. Master must share reset_i.
// - FSM: IDLE -> LATCH -> LAUNCH -> RUN -> FIN -> IDLE.
// - IDLE: if any req_i is high and m_busy_i=0, pick the first requesting index at or after ptr (wrapping);
//   register the winner; go to LATCH. If none, stay.
// - LATCH: copy the winner's rw/ur/devadr/regadr/datnum into registers; set gnt_o; datnum 0 is latched as 1.
// - LAUNCH: m_enable_o=1 and the timeout counter runs.
//   - m_busy_i seen 1: drop enable, go to RUN.
//   - Counter reaches START_TO: drop enable, go to FIN with err.
// - RUN: on m_dvalid_i:
//   - latched rw=1: rdat_o<=m_dat_i, rvalid_o[g] pulses the next cycle.
//   - rw=0: wnext_o[g] pulses the next cycle.
//   - m_busy_i falling (1->0): go to FIN.
// - FIN: one cycle. done_o[g] or err_o[g] pulses; gnt_o drops next cycle; ptr<=g+1 mod NREQ; go to IDLE.
// - Latency: req_i rising in idle -> m_enable_o high after 3 cycles (IDLE pick, LATCH, LAUNCH).
// - Descriptor inputs are sampled only in LATCH; later changes are ignored until the next grant.
// - Dropping req_i while granted does not abort; the transaction completes and done/err still pulses.
// - Simultaneous requests: strict round-robin; last winner has lowest priority next round; no starvation.
// - m_dvalid_i coinciding with the busy fall is still forwarded before FIN.
// - At most one bit of gnt_o/done_o/err_o/rvalid_o/wnext_o is set at any time.
// STRUCTURE
// - Shared include i2c_defs.vh: FSM state codes (3-bit), I2C_DEVADR_W=7, I2C_DATA_W=8, I2C_CNT_W=16.
// - One sub-module: i2c_rr_pick (combinational round-robin priority pick, NREQ-wide; outputs one-hot + index).
// - Top holds the FSM, descriptor registers, timeout counter and strobe steering.
// TESTING
// - Single read: req_i=4'b0010, rw=1, devadr=7'h50, regadr=8'h10, datnum=2, master model returns A5,3C
//   -> gnt_o=0010; two rvalid_o[1] pulses with rdat_o A5 then 3C; one done_o[1] pulse.
// - Contention: req_i=4'b1011 held, ptr=0
//   -> grant order 0,1,3,0; each done_o is followed by the next grant within 3 cycles.
// - Write of 3 bytes, requester 2: three m_dvalid_i pulses -> three wnext_o[2] pulses;
//   m_dat_o tracks wdat_i[23:16]; done_o[2] at the busy fall.
// - Start timeout: master model holds m_busy_i=0
//   -> m_enable_o high for exactly 16 cycles; err_o pulses; no done_o; ptr advances.
// - Request withdrawal: req_i[0] dropped during RUN -> transaction runs to end; done_o[0] pulses.
// - Async reset asserted mid-RUN -> all outputs 0 immediately; after release, grant restarts from requester 0.

Source files
------------

// File: rtl/i2c_req_arbiter_pkg.sv
// Shared definitions for the I2C request arbiter: bus widths and FSM state encoding.
package i2c_req_arbiter_pkg;

  localparam int I2C_DEVADR_W = 7;
  localparam int I2C_DATA_W   = 8;
  localparam int I2C_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module i2c_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  localparam int unsigned N = NREQ;

  int unsigned k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k[IW-1:0]]) begin
        any               = 1'b1;
        onehot[k[IW-1:0]] = 1'b1;
        idx               = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte-transaction master between NREQ requesters.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int START_TO = 16
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NREQ-1:0]             req_i,
  input  logic [NREQ-1:0]             rw_i,
  input  logic [NREQ-1:0]             ur_i,
  input  logic [I2C_DEVADR_W*NREQ-1:0] devadr_i,
  input  logic [I2C_DATA_W*NREQ-1:0]  regadr_i,
  input  logic [I2C_CNT_W*NREQ-1:0]   datnum_i,
  input  logic [I2C_DATA_W*NREQ-1:0]  wdat_i,
  output logic [NREQ-1:0]             gnt_o,
  output logic [NREQ-1:0]             wnext_o,
  output logic [NREQ-1:0]             rvalid_o,
  output logic [I2C_DATA_W-1:0]       rdat_o,
  output logic [NREQ-1:0]             done_o,
  output logic [NREQ-1:0]             err_o,
  output logic                        m_enable_o,
  output logic                        m_rw_o,
  output logic                        m_ur_o,
  output logic [I2C_DEVADR_W-1:0]     m_devadr_o,
  output logic [I2C_DATA_W-1:0]       m_regadr_o,
  output logic [I2C_CNT_W-1:0]        m_datnum_o,
  output logic [I2C_DATA_W-1:0]       m_dat_o,
  input  logic [I2C_DATA_W-1:0]       m_dat_i,
  input  logic                        m_busy_i,
  input  logic                        m_dvalid_i
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(START_TO + 1);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic [NREQ-1:0]   win_oh;
  logic [TW-1:0]     tcnt;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic [I2C_DEVADR_W-1:0] sel_devadr;
  logic [I2C_DATA_W-1:0]   sel_regadr;
  logic [I2C_CNT_W-1:0]    sel_datnum;
  logic [I2C_DATA_W-1:0]   sel_wdat;

  i2c_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_devadr = devadr_i[I2C_DEVADR_W*win +: I2C_DEVADR_W];
    sel_regadr = regadr_i[I2C_DATA_W*win +: I2C_DATA_W];
    sel_datnum = datnum_i[I2C_CNT_W*win +: I2C_CNT_W];
    sel_wdat   = wdat_i[I2C_DATA_W*win +: I2C_DATA_W];
  end

  // Write data is gated by the grant so the bus reads zero whenever nobody owns the master.
  assign m_dat_o = (gnt_o != '0) ? sel_wdat : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win        <= '0;
      win_oh     <= '0;
      tcnt       <= '0;
      gnt_o      <= '0;
      wnext_o    <= '0;
      rvalid_o   <= '0;
      rdat_o     <= '0;
      done_o     <= '0;
      err_o      <= '0;
      m_enable_o <= 1'b0;
      m_rw_o     <= 1'b0;
      m_ur_o     <= 1'b0;
      m_devadr_o <= '0;
      m_regadr_o <= '0;
      m_datnum_o <= '0;
    end else begin
      wnext_o  <= '0;
      rvalid_o <= '0;
      done_o   <= '0;
      err_o    <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any && !m_busy_i) begin
            win    <= pick_idx;
            win_oh <= pick_oh;
            state  <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          m_rw_o     <= rw_i[win];
          m_ur_o     <= ur_i[win];
          m_devadr_o <= sel_devadr;
          m_regadr_o <= sel_regadr;
          m_datnum_o <= (sel_datnum == '0) ? I2C_CNT_W'(1) : sel_datnum;
          gnt_o      <= win_oh;
          m_enable_o <= 1'b1;
          tcnt       <= '0;
          state      <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          if (m_busy_i) begin
            m_enable_o <= 1'b0;
            state      <= ST_RUN;
          end else if (tcnt == TW'(START_TO - 1)) begin
            m_enable_o <= 1'b0;
            err_o      <= gnt_o;
            state      <= ST_FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_RUN: begin
          // RUN is entered with busy high, so the first low busy here is the falling edge.
          if (m_dvalid_i) begin
            if (m_rw_o) begin
              rdat_o   <= m_dat_i;
              rvalid_o <= gnt_o;
            end else begin
              wnext_o <= gnt_o;
            end
          end
          if (!m_busy_i) begin
            done_o <= gnt_o;
            state  <= ST_FIN;
          end
        end
        ST_FIN: begin
          gnt_o <= '0;
          ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
